// File: rtl/uart_rx_ctrl.sv
// UART receive control: rx synchronizer, 3-sample majority vote, frame sequencing
// and parity/stop checking that drives the downstream RX deserializer.
module uart_rx_ctrl #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  sampled_bit,
    output logic                  en_shift,
    output logic                  en_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int unsigned PW  = PRESCALE_W;
    localparam int unsigned BCW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t         state, state_c;
    logic [1:0]     sync;
    logic           rx_s;
    logic [PW-1:0]  p_lat;
    logic           pe_lat, pt_lat;
    logic [PW-1:0]  e;
    logic [BCW-1:0] bit_cnt;
    logic [2:0]     smp;
    logic           acc, par_hold;

    logic [PW-1:0]  half_c;
    logic           at_d_c, at_end_c, vote_c, start_det_c, last_bit_c;
    logic           sampled_c, en_shift_c, en_out_c, par_err_c, stp_err_c, busy_c;

    assign rx_s        = sync[1];
    assign half_c      = p_lat >> 1;
    assign at_d_c      = (e == half_c + PW'(2));
    assign at_end_c    = (e == p_lat - PW'(1));
    assign vote_c      = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign start_det_c = (state == S_IDLE) && !rx_s;
    assign last_bit_c  = (bit_cnt == BCW'(DATA_SIZE - 1));

    // Two-flop synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], rx_in};
    end

    // Frame configuration is frozen at start detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_lat  <= '0;
            pe_lat <= 1'b0;
            pt_lat <= 1'b0;
        end else if (start_det_c) begin
            p_lat  <= prescale;
            pe_lat <= par_en;
            pt_lat <= par_typ;
        end
    end

    // Edge counter: the detect cycle is e=0, so START's first cycle is e=1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e       <= '0;
            bit_cnt <= '0;
        end else begin
            if (start_det_c)            e <= PW'(1);
            else if (state_c == S_IDLE) e <= '0;
            else if (at_end_c)          e <= '0;
            else                        e <= e + PW'(1);

            if (state == S_START)                bit_cnt <= '0;
            else if (state == S_DATA && at_end_c) bit_cnt <= bit_cnt + BCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp <= '0;
        end else if (state != S_IDLE) begin
            if (e == half_c - PW'(1)) smp[0] <= rx_s;
            if (e == half_c)          smp[1] <= rx_s;
            if (e == half_c + PW'(1)) smp[2] <= rx_s;
        end
    end

    // Parity accumulates data bits; the mismatch is held until the stop decision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= 1'b0;
            par_hold <= 1'b0;
        end else if (start_det_c) begin
            acc      <= 1'b0;
            par_hold <= 1'b0;
        end else if (state == S_DATA && at_d_c) begin
            acc      <= acc ^ vote_c;
        end else if (state == S_PARITY && at_d_c) begin
            par_hold <= acc ^ vote_c ^ pt_lat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_c;
    end

    always_comb begin
        state_c = state;
        case (state)
            S_IDLE:   if (!rx_s) state_c = S_START;
            S_START: begin
                if (at_d_c && vote_c) state_c = S_IDLE;
                else if (at_end_c)    state_c = S_DATA;
            end
            S_DATA:   if (at_end_c && last_bit_c) state_c = pe_lat ? S_PARITY : S_STOP;
            S_PARITY: if (at_end_c) state_c = S_STOP;
            S_STOP:   if (at_d_c) state_c = S_IDLE;
            default:  state_c = S_IDLE;
        endcase
    end

    always_comb begin
        sampled_c  = sampled_bit;
        en_shift_c = 1'b0;
        en_out_c   = 1'b0;
        par_err_c  = 1'b0;
        stp_err_c  = 1'b0;
        busy_c     = (state_c != S_IDLE);
        if (state != S_IDLE && at_d_c) sampled_c = vote_c;
        case (state)
            S_DATA: en_shift_c = at_d_c;
            S_STOP: begin
                if (at_d_c) begin
                    stp_err_c = !vote_c;
                    par_err_c = par_hold;
                    en_out_c  = vote_c && !par_hold;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampled_bit <= 1'b0;
            en_shift    <= 1'b0;
            en_out      <= 1'b0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sampled_bit <= sampled_c;
            en_shift    <= en_shift_c;
            en_out      <= en_out_c;
            data_valid  <= en_out;
            par_err     <= par_err_c;
            stp_err     <= stp_err_c;
            busy        <= busy_c;
        end
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side control stage of the UART RX path. It sits directly upstream of the RX deserializer and drives that block's serial input, shift enable and output-load enable.
- Synchronizes and oversamples the raw rx line, then majority-votes each bit.
- Sequences start / data / parity / stop bits with an FSM.
- Checks parity and stop bits and flags received bytes as valid or errored.

Parameters:
DATA_SIZE, 8, number of data bits per frame (must match the deserializer)
PRESCALE_W, 6, width of the prescale input

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rx_in  input  1  raw serial line, idle high, asynchronous to clk
prescale  input  PRESCALE_W  oversampling ratio P (clk cycles per bit), supported even values 8..32
par_en  input  1  1 = frame carries a parity bit
par_typ  input  1  0 = even parity, 1 = odd parity
sampled_bit  output  1  majority-voted bit value; feeds deserializer serial input
en_shift  output  1  one-cycle pulse per data bit; feeds deserializer shift enable
en_out  output  1  one-cycle pulse on a good frame; feeds deserializer output-load enable
data_valid  output  1  one-cycle pulse, one cycle after en_out (deserializer output register now holds the byte)
par_err  output  1  one-cycle pulse on parity mismatch
stp_err  output  1  one-cycle pulse on stop bit sampled 0
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset:
  - All outputs 0; FSM to IDLE; counters 0; parity accumulator 0.
  - Two-flop rx synchronizer resets to 1 (line idle). Reset mid-frame aborts the frame with no pulses.
- Synchronizer: rx_s = rx_in delayed 2 clk. All logic below uses rx_s only.
- Prescale latch:
  - prescale, par_en and par_typ are captured when a start is detected.
  - Changes mid-frame have no effect until the next frame.
- Edge counter e:
  - The start-detect cycle is e=0; e increments each clk and wraps P-1 -> 0 at each bit boundary.
  - Bit counter increments on each wrap.
- Sampling:
  - rx_s is sampled at e = P/2-1, P/2 and P/2+1; majority of the 3 samples is registered into sampled_bit at e = P/2+2, the decision cycle D.
  - sampled_bit holds its value between decisions.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START (e=0).
  - START: at D, if sampled_bit==1 (glitch) -> IDLE with no pulses; else continue. At e=P-1 -> DATA.
  - DATA: at D, en_shift=1 for exactly that cycle and the parity accumulator ^= sampled bit. After DATA_SIZE bits, at e=P-1 -> PARITY if par_en, else STOP. Bits are LSB first.
  - PARITY: at D, error = (acc ^ bit ^ par_typ) != 0. The error is held internally and reported at the stop decision. At e=P-1 -> STOP.
  - STOP: at D, evaluate the frame:
    - stp_err = !bit; par_err = held parity error.
    - If neither error, en_out=1.
    - Next state IDLE in the same cycle, i.e. mid-stop-bit, so a start bit arriving directly after the stop bit is caught.
- Error and timing rules:
  - data_valid = en_out delayed 1 clk.
  - par_err and stp_err may pulse together; either one suppresses en_out and data_valid.
  - The parity accumulator clears on entry to START.
  - A line held low after the stop bit re-triggers START immediately; a break yields stp_err then a glitch-reject or a new frame.
  - en_shift, en_out, par_err and stp_err are mutually exclusive with en_shift in time (different bit slots).
- Prescale limits: P < 8 or odd P is not supported; behaviour is undefined.

Test Plan:
- P=8, par_en=0, byte 0xA5 8N1 -> 8 en_shift pulses with sampled_bit 1,0,1,0,0,1,0,1; en_out once at stop D; data_valid next cycle; deserializer out_reg = 0xA5; no error pulses.
- P=16, par_en=1, par_typ=0, byte 0x3C with parity bit 1 (wrong) -> par_err pulse at stop D; no en_out or data_valid. Repeat with parity bit 0 -> en_out pulse, out_reg = 0x3C.
- P=8, byte 0x55, stop bit driven 0 -> stp_err pulse; no en_out; FSM back in IDLE; busy low.
- P=16, rx_in low for 3 cycles then high -> START, glitch reject at D, return to IDLE; zero en_shift and no error pulses.
- P=16, byte 0x0F with a 1-cycle inverted spike at e=P/2 in bit 2 -> majority vote keeps the correct value; out_reg = 0x0F.
- Further sequencing cases:
  - Back-to-back frames 0x81, 0x7E at P=8 with no idle gap -> two data_valid pulses, both bytes correct.
  - rst asserted during bit 4 of a frame -> all outputs 0 and IDLE.
  - A following clean frame is then received correctly.
